// File: rtl/ddr_queue_pkg.sv
// Shared widths, read-FSM encoding and one-hot helper for the DDR queue scheduler.
package ddr_queue_pkg;
   localparam int unsigned DEF_NQ    = 4;
   localparam int unsigned DEF_SLOTS = 16;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned LEN_W     = 16;
   localparam int unsigned STRB_W    = 8;
   localparam int unsigned SLOT_W    = $clog2(DEF_SLOTS);
   localparam int unsigned QIDX_W    = $clog2(DEF_NQ);

   typedef enum logic [1:0] {RD_IDLE, RD_ARB, RD_REQ, RD_WAIT} rd_state_e;

   // Index of a one-hot vector; callers qualify the input with $onehot first.
   function automatic logic [4:0] oh2idx(input logic [31:0] oh);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | 5'(i);
      end
      return idx;
   endfunction
endpackage

// File: rtl/ddr_queue_rr_arbiter.sv
// Combinational round-robin: first requester at or after ptr_i, wrapping; zero latency.
module ddr_queue_rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
)(
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);
   logic [IW-1:0] pos;
   logic          found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      pos   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = IW'((32'(ptr_i) + k) % N);
         if (!found && req_i[pos]) begin
            found      = 1'b1;
            gnt_o[pos] = 1'b1;
            idx_o      = pos;
         end
      end
   end
endmodule

// File: rtl/ddr_queue_scheduler.sv
// Per-queue DDR slot allocator, descriptor FIFOs and round-robin read-back scheduler.
// Allocation is combinational; one read outstanding, held stable until i_rd_ddr_ready.
module ddr_queue_scheduler
   import ddr_queue_pkg::*;
#(
   parameter int unsigned P_DDR_LOCAL_QUEUE  = DEF_NQ,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = ADDR_W,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] P_BASE_ADDR = 32'h0000_0000,
   parameter int unsigned P_SLOT_BYTES       = 2048,
   parameter int unsigned P_SLOTS            = DEF_SLOTS
)(
   input  logic                          i_axis_clk,
   input  logic                          i_axis_rst,
   input  logic                          i_wr_ddr_valid,
   input  logic [LEN_W-1:0]              i_wr_ddr_len,
   input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_wr_ddr_queue,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] o_wr_ddr_addr,
   output logic                          o_wr_ddr_ready,
   input  logic                          i_wr_ddr_cpl_valid,
   output logic                          o_wr_ddr_cpl_ready,
   input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_wr_ddr_cpl_queue,
   input  logic [LEN_W-1:0]              i_wr_ddr_cpl_len,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_wr_ddr_cpl_addr,
   input  logic [STRB_W-1:0]             i_wr_ddr_cpl_strb,
   output logic                          o_rd_ddr_valid,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] o_rd_ddr_addr,
   output logic [LEN_W-1:0]              o_rd_ddr_len,
   output logic [STRB_W-1:0]             o_rd_ddr_strb,
   input  logic                          i_rd_ddr_ready,
   input  logic                          i_rd_ddr_cpl,
   input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_queue_rd_en,
   output logic [P_DDR_LOCAL_QUEUE-1:0]  o_queue_empty,
   output logic [P_DDR_LOCAL_QUEUE-1:0]  o_queue_full,
   output logic                          o_err
);
   localparam int unsigned NQ    = P_DDR_LOCAL_QUEUE;
   localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned QW    = (NQ > 1) ? $clog2(NQ) : 1;
   localparam int unsigned SW    = $clog2(P_SLOTS);
   localparam int unsigned CW    = SW + 1;
   localparam int unsigned DW    = AW + LEN_W + STRB_W;
   localparam int unsigned SB_SH = $clog2(P_SLOT_BYTES);

   rd_state_e     state_q, state_d;
   logic [SW-1:0] alloc_ptr_q [NQ], alloc_ptr_d [NQ];
   logic [SW-1:0] head_q [NQ], head_d [NQ], tail_q [NQ], tail_d [NQ];
   logic [CW-1:0] free_q [NQ], free_d [NQ], cnt_q [NQ], cnt_d [NQ];
   logic [NQ-1:0] empty_q, full_q, eligible, arb_gnt;
   logic [QW-1:0] wq, cq, arb_idx, gidx_q, gidx_d, rr_q, rr_d;
   logic          len_ok, wr_bad, cpl_bad, push, pop, rel, ram_rd_en, err_q;
   logic [DW-1:0] desc_ram [NQ*P_SLOTS];
   logic [DW-1:0] rd_desc_q;

   assign wq       = QW'(oh2idx(32'(i_wr_ddr_queue)));
   assign cq       = QW'(oh2idx(32'(i_wr_ddr_cpl_queue)));
   assign len_ok   = (i_wr_ddr_len != '0) && (32'(i_wr_ddr_len) <= P_SLOT_BYTES);
   assign wr_bad   = i_wr_ddr_valid && !($onehot(i_wr_ddr_queue) && len_ok);
   assign cpl_bad  = i_wr_ddr_cpl_valid && !$onehot(i_wr_ddr_cpl_queue);
   assign push     = i_wr_ddr_cpl_valid && o_wr_ddr_cpl_ready && $onehot(i_wr_ddr_cpl_queue);
   assign eligible = ~empty_q & i_queue_rd_en;

   assign o_wr_ddr_addr      = P_BASE_ADDR + (AW'({wq, alloc_ptr_q[wq]}) << SB_SH);
   assign o_wr_ddr_ready     = !i_axis_rst && i_wr_ddr_valid && $onehot(i_wr_ddr_queue) &&
                               len_ok && (free_q[wq] != '0);
   assign o_wr_ddr_cpl_ready = !i_axis_rst;
   assign o_rd_ddr_valid     = (state_q == RD_REQ);
   assign {o_rd_ddr_addr, o_rd_ddr_len, o_rd_ddr_strb} = rd_desc_q;
   assign o_queue_empty      = empty_q;
   assign o_queue_full       = full_q;
   assign o_err              = err_q;

   ddr_queue_rr_arbiter #(.N(NQ), .IW(QW)) u_arb (
      .req_i (eligible),
      .ptr_i (rr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   always_comb begin
      state_d   = state_q;
      gidx_d    = gidx_q;
      rr_d      = rr_q;
      ram_rd_en = 1'b0;
      pop       = 1'b0;
      rel       = 1'b0;
      unique case (state_q)
         RD_IDLE: if (|eligible) state_d = RD_ARB;
         RD_ARB: begin
            // Eligibility is re-evaluated here; an enable dropped during IDLE->ARB backs off.
            if (|arb_gnt) begin
               gidx_d    = arb_idx;
               ram_rd_en = 1'b1;
               state_d   = RD_REQ;
            end else begin
               state_d = RD_IDLE;
            end
         end
         RD_REQ: if (i_rd_ddr_ready) begin
            pop     = 1'b1;
            rr_d    = (32'(gidx_q) == NQ - 1) ? '0 : gidx_q + QW'(1);
            state_d = RD_WAIT;
         end
         RD_WAIT: if (i_rd_ddr_cpl) begin
            rel     = 1'b1;
            state_d = RD_IDLE;
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NQ; i++) begin
         alloc_ptr_d[i] = alloc_ptr_q[i] + SW'(o_wr_ddr_ready && (wq == QW'(i)));
         free_d[i]      = free_q[i] - CW'(o_wr_ddr_ready && (wq == QW'(i)))
                                    + CW'(rel && (gidx_q == QW'(i)));
         tail_d[i]      = tail_q[i] + SW'(push && (cq == QW'(i)));
         head_d[i]      = head_q[i] + SW'(pop && (gidx_q == QW'(i)));
         cnt_d[i]       = cnt_q[i] + CW'(push && (cq == QW'(i)))
                                   - CW'(pop && (gidx_q == QW'(i)));
      end
   end

   always_ff @(posedge i_axis_clk or posedge i_axis_rst) begin
      if (i_axis_rst) begin
         state_q   <= RD_IDLE;
         gidx_q    <= '0;
         rr_q      <= '0;
         err_q     <= 1'b0;
         rd_desc_q <= '0;
         empty_q   <= '1;
         full_q    <= '0;
         for (int i = 0; i < NQ; i++) begin
            alloc_ptr_q[i] <= '0;
            head_q[i]      <= '0;
            tail_q[i]      <= '0;
            cnt_q[i]       <= '0;
            free_q[i]      <= CW'(P_SLOTS);
         end
      end else begin
         state_q     <= state_d;
         gidx_q      <= gidx_d;
         rr_q        <= rr_d;
         err_q       <= err_q | wr_bad | cpl_bad;
         alloc_ptr_q <= alloc_ptr_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         free_q      <= free_d;
         if (ram_rd_en) rd_desc_q <= desc_ram[{arb_idx, head_q[arb_idx]}];
         for (int i = 0; i < NQ; i++) begin
            empty_q[i] <= (cnt_d[i] == '0);
            full_q[i]  <= (free_d[i] == '0);
         end
      end
   end

   always_ff @(posedge i_axis_clk) begin
      if (push) desc_ram[{cq, tail_q[cq]}] <= {i_wr_ddr_cpl_addr, i_wr_ddr_cpl_len, i_wr_ddr_cpl_strb};
   end
endmodule

// File: tb/tb_ddr_queue_scheduler.sv
// Directed-vector bench for ddr_queue_scheduler with hand-computed expectations.
module tb_ddr_queue_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_len = '0;
   logic [3:0]  wr_queue = '0;
   logic [31:0] wr_addr;
   logic        wr_ready;
   logic        cpl_valid = 1'b0;
   logic        cpl_ready;
   logic [3:0]  cpl_queue = '0;
   logic [15:0] cpl_len = '0;
   logic [31:0] cpl_addr = '0;
   logic [7:0]  cpl_strb = '0;
   logic        rd_valid;
   logic [31:0] rd_addr;
   logic [15:0] rd_len;
   logic [7:0]  rd_strb;
   logic        rd_ready = 1'b0;
   logic        rd_cpl = 1'b0;
   logic [3:0]  rd_en = '0;
   logic [3:0]  q_empty, q_full;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ddr_queue_scheduler dut (
      .i_axis_clk         (clk),
      .i_axis_rst         (rst),
      .i_wr_ddr_valid     (wr_valid),
      .i_wr_ddr_len       (wr_len),
      .i_wr_ddr_queue     (wr_queue),
      .o_wr_ddr_addr      (wr_addr),
      .o_wr_ddr_ready     (wr_ready),
      .i_wr_ddr_cpl_valid (cpl_valid),
      .o_wr_ddr_cpl_ready (cpl_ready),
      .i_wr_ddr_cpl_queue (cpl_queue),
      .i_wr_ddr_cpl_len   (cpl_len),
      .i_wr_ddr_cpl_addr  (cpl_addr),
      .i_wr_ddr_cpl_strb  (cpl_strb),
      .o_rd_ddr_valid     (rd_valid),
      .o_rd_ddr_addr      (rd_addr),
      .o_rd_ddr_len       (rd_len),
      .o_rd_ddr_strb      (rd_strb),
      .i_rd_ddr_ready     (rd_ready),
      .i_rd_ddr_cpl       (rd_cpl),
      .i_queue_rd_en      (rd_en),
      .o_queue_empty      (q_empty),
      .o_queue_full       (q_full),
      .o_err              (err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cpl_valid = 1'b0; rd_ready = 1'b0; rd_cpl = 1'b0; rd_en = '0;
      wr_valid = 1'b1; wr_queue = 4'b0001; wr_len = 16'd64;
      #1;
      check("rst_wr_rdy", wr_ready, 1'b0);
      check("rst_cpl_rdy", cpl_ready, 1'b0);
      wr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic alloc(input logic [3:0] q, input logic [15:0] len, input logic [31:0] exp_addr,
                        input string tag);
      @(negedge clk);
      wr_valid = 1'b1; wr_queue = q; wr_len = len;
      #1;
      check({tag, "_rdy"}, wr_ready, 1'b1);
      check({tag, "_addr"}, wr_addr, exp_addr);
      @(posedge clk);
      #1 wr_valid = 1'b0;
   endtask

   task automatic complete(input logic [3:0] q, input logic [15:0] len, input logic [31:0] addr,
                           input logic [7:0] strb);
      @(negedge clk);
      cpl_valid = 1'b1; cpl_queue = q; cpl_len = len; cpl_addr = addr; cpl_strb = strb;
      #1;
      check("cpl_rdy", cpl_ready, 1'b1);
      @(posedge clk);
      #1 cpl_valid = 1'b0;
   endtask

   task automatic rd_req(input logic [31:0] a, input logic [15:0] len, input logic [7:0] strb,
                         input string tag);
      int k;
      k = 0;
      @(negedge clk);
      while (!rd_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_valid"}, rd_valid, 1'b1);
      if (rd_valid) begin
         check({tag, "_addr"}, rd_addr, a);
         check({tag, "_len"}, rd_len, len);
         check({tag, "_strb"}, rd_strb, strb);
         rd_ready = 1'b1;
         @(posedge clk);
         #1 rd_ready = 1'b0;
         check({tag, "_drop"}, rd_valid, 1'b0);
      end
   endtask

   task automatic rd_done();
      @(negedge clk);
      rd_cpl = 1'b1;
      @(posedge clk);
      #1 rd_cpl = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0]  tq [6];
      logic [31:0] ta [6];
      logic [15:0] tl [6];
      logic [7:0]  ts [6];
      int seen, lat;

      // reset state
      do_reset();
      @(negedge clk);
      check("rst_empty", q_empty, 4'hF);
      check("rst_full", q_full, 4'h0);
      check("rst_err", err, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_addr", rd_addr, 32'h0);

      // sequential slot addresses on queue 0
      alloc(4'b0001, 16'd64, 32'h0000_0000, "s1_a0");
      alloc(4'b0001, 16'd64, 32'h0000_0800, "s1_a1");
      alloc(4'b0001, 16'd64, 32'h0000_1000, "s1_a2");
      @(negedge clk);
      check("s1_full0", q_full[0], 1'b0);

      // single round trip on queue 2, then prove all 16 slots are free again
      do_reset();
      alloc(4'b0100, 16'd100, 32'h0001_0000, "s2_alloc");
      complete(4'b0100, 16'd100, 32'h0001_0000, 8'h0F);
      @(negedge clk);
      check("s2_empty_after_push", q_empty, 4'b1011);
      rd_en = 4'b0100;
      rd_req(32'h0001_0000, 16'd100, 8'h0F, "s2_rd");
      check("s2_empty_after_pop", q_empty[2], 1'b1);
      rd_done();
      for (int i = 0; i < 16; i++)
         alloc(4'b0100, 16'd64, 32'h0001_0000 + 32'(((i + 1) % 16) * 2048), "s2_refill");
      @(negedge clk);
      check("s2_full2", q_full, 4'b0100);

      // fill queue 1, reject the 17th, release one slot
      do_reset();
      for (int i = 0; i < 16; i++)
         alloc(4'b0010, 16'd64, 32'h0000_8000 + 32'(i * 2048), "s3_fill");
      @(negedge clk);
      check("s3_full1", q_full, 4'b0010);
      wr_valid = 1'b1; wr_queue = 4'b0010; wr_len = 16'd64;
      #1 check("s3_17th_rdy", wr_ready, 1'b0);
      @(posedge clk);
      #1 wr_valid = 1'b0;
      @(negedge clk);
      check("s3_noerr", err, 1'b0);
      complete(4'b0010, 16'd64, 32'h0000_8000, 8'hFF);
      rd_en = 4'b0010;
      rd_req(32'h0000_8000, 16'd64, 8'hFF, "s3_rd");
      check("s3_full_in_wait", q_full[1], 1'b1);
      @(negedge clk);
      wr_valid = 1'b1; wr_queue = 4'b0010; wr_len = 16'd64;
      rd_cpl = 1'b1;
      #1 check("s3_rdy_before_free", wr_ready, 1'b0);
      @(posedge clk);
      #1 rd_cpl = 1'b0;
      check("s3_rdy_after_free", wr_ready, 1'b1);
      check("s3_wrap_addr", wr_addr, 32'h0000_8000);
      @(posedge clk);
      #1 wr_valid = 1'b0;

      // round-robin over queues 0, 1, 3
      do_reset();
      tq = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
      ta = '{32'h0, 32'h8000, 32'h18000, 32'h800, 32'h8800, 32'h18800};
      tl = '{16'd10, 16'd20, 16'd30, 16'd11, 16'd21, 16'd31};
      ts = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};
      for (int i = 0; i < 6; i++) alloc(tq[i], tl[i], ta[i], "s4_alloc");
      for (int i = 0; i < 6; i++) complete(tq[i], tl[i], ta[i], ts[i]);
      @(negedge clk);
      check("s4_empty", q_empty, 4'b0100);
      rd_en = 4'hF;
      for (int i = 0; i < 6; i++) begin
         rd_req(ta[i], tl[i], ts[i], "s4_rr");
         rd_done();
      end
      @(negedge clk);
      check("s4_all_empty", q_empty, 4'hF);

      // read enable gating
      do_reset();
      alloc(4'b0001, 16'd64, 32'h0, "s5_alloc");
      complete(4'b0001, 16'd64, 32'h0, 8'h03);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rd_valid) seen++;
      end
      check("s5_gated", 32'(seen), 32'd0);
      rd_en = 4'b0001;
      lat = 0;
      while (!rd_valid && lat < 3) begin
         @(negedge clk);
         lat++;
      end
      check("s5_req_in_3", rd_valid, 1'b1);
      rd_req(32'h0, 16'd64, 8'h03, "s5_rd");
      rd_done();

      // bad requests, max length, reset during WAIT
      do_reset();
      alloc(4'b0001, 16'd2048, 32'h0, "s6_maxlen");
      @(negedge clk);
      wr_valid = 1'b1; wr_queue = 4'b0001; wr_len = 16'd0;
      #1 check("s6_len0_rdy", wr_ready, 1'b0);
      check("s6_err_not_yet", err, 1'b0);
      @(posedge clk);
      #1 wr_valid = 1'b0;
      check("s6_err_set", err, 1'b1);
      @(negedge clk);
      wr_valid = 1'b1; wr_queue = 4'b0011; wr_len = 16'd64;
      #1 check("s6_2hot_rdy", wr_ready, 1'b0);
      wr_queue = 4'b0001; wr_len = 16'd2049;
      #1 check("s6_len2049_rdy", wr_ready, 1'b0);
      wr_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("s6_err_sticky", err, 1'b1);
      complete(4'b0001, 16'd2048, 32'h0, 8'hFF);
      rd_en = 4'b0001;
      rd_req(32'h0, 16'd2048, 8'hFF, "s6_rd");
      @(negedge clk);
      rst = 1'b1;
      wr_valid = 1'b1; wr_queue = 4'b0001; wr_len = 16'd64;
      #1;
      check("s6_rst_rd_valid", rd_valid, 1'b0);
      check("s6_rst_rd_addr", rd_addr, 32'h0);
      check("s6_rst_empty", q_empty, 4'hF);
      check("s6_rst_err", err, 1'b0);
      check("s6_rst_wr_rdy", wr_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("s6_post_rst_rdy", wr_ready, 1'b1);
      check("s6_post_rst_addr", wr_addr, 32'h0);
      @(posedge clk);
      #1 wr_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("s6_no_stale_rd", rd_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ddr_queue_scheduler.md
Name: ddr_queue_scheduler

Overview:
- Manages the DDR-backed local queues behind the AXI4 DDR bus block (AXIS write path plus AXI read-back path).
- Hands out per-queue DDR slot addresses to the write path and collects write completions into per-queue descriptor FIFOs.
- Round-robins read-back requests across non-empty, enabled queues. Frees a slot only when its read completes.

Parameters:
- P_DDR_LOCAL_QUEUE, 4, number of local queues; queue select buses are one-hot of this width.
- C_M_AXI_ADDR_WIDTH, 32, DDR address width.
- P_BASE_ADDR, 32'h0000_0000, DDR byte address of queue 0, slot 0.
- P_SLOT_BYTES, 2048, bytes per slot (power of 2, ≥ max packet length).
- P_SLOTS, 16, slots per queue (power of 2); also the descriptor FIFO depth per queue.

Ports:
- i_axis_clk  in  1  single clock for all logic.
- i_axis_rst  in  1  asynchronous, active-high reset.
- i_wr_ddr_valid  in  1  write path requests a slot.
- i_wr_ddr_len  in  16  packet length, bytes.
- i_wr_ddr_queue  in  P_DDR_LOCAL_QUEUE  target queue, one-hot.
- o_wr_ddr_addr  out  C_M_AXI_ADDR_WIDTH  allocated slot address.
- o_wr_ddr_ready  out  1  allocation accepted.
- i_wr_ddr_cpl_valid  in  1  a DDR write has finished.
- o_wr_ddr_cpl_ready  out  1  completion accepted.
- i_wr_ddr_cpl_queue  in  P_DDR_LOCAL_QUEUE  queue of the completed write.
- i_wr_ddr_cpl_len  in  16  bytes written.
- i_wr_ddr_cpl_addr  in  C_M_AXI_ADDR_WIDTH  slot address of the completed write.
- i_wr_ddr_cpl_strb  in  8  last-beat byte strobe.
- o_rd_ddr_valid  out  1  read request.
- o_rd_ddr_addr  out  C_M_AXI_ADDR_WIDTH  read address.
- o_rd_ddr_len  out  16  read length, bytes.
- o_rd_ddr_strb  out  8  last-beat strobe.
- i_rd_ddr_ready  in  1  read path accepts the request.
- i_rd_ddr_cpl  in  1  one-cycle pulse: read-back finished.
- i_queue_rd_en  in  P_DDR_LOCAL_QUEUE  per-queue read enable (time-slot gating).
- o_queue_empty  out  P_DDR_LOCAL_QUEUE  descriptor FIFO empty.
- o_queue_full  out  P_DDR_LOCAL_QUEUE  no free slots.
- o_err  out  1  sticky bad-request flag.

Behaviour:
- Reset (async, active-high):
  - all slot pointers and descriptor pointers = 0; free count = P_SLOTS per queue.
  - FSM enters IDLE; round-robin pointer = queue 0.
  - o_rd_ddr_valid = 0, o_rd_ddr_addr/len/strb = 0, o_err = 0, o_queue_empty = all 1, o_queue_full = all 0.
  - o_wr_ddr_ready = 0 and o_wr_ddr_cpl_ready = 0 while reset is asserted.
  - Reset mid-transfer drops every allocation and descriptor.
- Allocation (combinational):
  - q = index of i_wr_ddr_queue.
  - o_wr_ddr_addr = P_BASE_ADDR + (q*P_SLOTS + alloc_ptr[q])*P_SLOT_BYTES.
  - o_wr_ddr_ready = valid & one-hot queue & 0 < len ≤ P_SLOT_BYTES & free[q] ≠ 0.
  - On handshake: alloc_ptr[q] increments mod P_SLOTS; free[q] decrements.
  - Bad request (queue not one-hot, len = 0, or len > P_SLOT_BYTES): ready stays low and o_err is set the next cycle, sticky until reset.
- Completion:
  - o_wr_ddr_cpl_ready = 1 whenever out of reset; the FIFO cannot overflow because it holds at most the allocated slots.
  - On valid: push {addr, len, strb} into the FIFO of queue cpl_queue.
  - Completions are in allocation order within each queue.
  - Non-one-hot cpl_queue: descriptor dropped, o_err set.
  - Descriptor store: one RAM of P_DDR_LOCAL_QUEUE*P_SLOTS entries, indexed {q, ptr}.
- Read FSM:
  - IDLE: eligible = ~o_queue_empty & i_queue_rd_en. If nonzero, go to ARB.
  - ARB: pick the first eligible queue at or after the rr pointer, wrapping. Read its head descriptor (1-cycle RAM latency), then go to REQ.
  - REQ: o_rd_ddr_valid = 1 with the descriptor fields held stable until i_rd_ddr_ready. On handshake, pop the FIFO, set rr = granted+1 mod N, go to WAIT.
  - WAIT: on i_rd_ddr_cpl, free[granted] increments, go to IDLE.
  - At most one read is outstanding.
  - i_queue_rd_en deasserting after ARB does not cancel the request.
- Simultaneous events:
  - Allocation and free on the same queue in one cycle: free count unchanged.
  - Push and pop on the same FIFO in one cycle: both take effect; the empty flag is computed from the post-update count.
- Status timing: o_queue_empty and o_queue_full are registered, one cycle after the count changes.

Decomposition:
- Package ddr_queue_pkg holds: descriptor field widths (addr, 16-bit len, 8-bit strb), slot index width clog2(P_SLOTS), queue index width, read FSM state encoding (IDLE/ARB/REQ/WAIT), and a one-hot-to-index function.
- Sub-module ddr_queue_rr_arbiter: combinational round-robin over the eligible mask, outputs a one-hot grant and an index.

Test Plan:
- Reset, allocate queue 0 len 64 three times → addrs 0x0, 0x800, 0x1000; o_queue_full[0] stays 0.
- Allocate len 100 on queue 2 (P_SLOTS=16, P_SLOT_BYTES=2048) → addr 0x10000; complete it with strb 0x0F; i_queue_rd_en=4'b0100 → read request addr 0x10000, len 100, strb 0x0F; i_rd_ddr_cpl → free[2] back to 16.
- Fill queue 1 with 16 allocations → o_queue_full[1]=1 and the 17th request sees ready=0; one read completion → ready rises on the following cycle.
- Queues 0, 1, 3 each hold 2 descriptors, all enabled → grant order 0,1,3,0,1,3.
- Queue 0 has descriptors but i_queue_rd_en=0 → no request issued; set the enable → request within 3 cycles.
- Request with len 0 or queue 4'b0011 → ready=0, o_err=1 stays set; assert reset during WAIT → o_rd_ddr_valid=0, empty all 1, err cleared.
